residue_mod3_seq: RTL and testbench

- Sequential, width-parametrised mod-3 residue generator and checker for the fault-tolerant arithmetic datapath.
- Consumes a W-bit operand two bits (one base-4 digit) per cycle. Since 4 ≡ 1 (mod 3), the residue is the mod-3 sum of the digits.
- Compares the result against an expected residue and flags mismatches and illegal residue codes.
- Residue accumulator state bits sit on the shared fault-injection bus, so campaigns can corrupt them per gate ID.

---
 rtl/residue_mod3_seq.sv | 143 ++++++++++++++
 tb/tb_residue_mod3_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/residue_mod3_seq.sv
// residue_mod3_seq: serial mod-3 residue generator/checker, one base-4 digit per cycle, LSB digit first.
// Latency: done pulses in the cycle after edge t0+N, where N = ceil(W/2).
//   A new start is accepted in the done cycle, so the block produces one result per N+1 cycles.
// Backpressure: none. A start seen while busy is ignored. R/err/code_err hold their values until the next done.
// Optional macro RESIDUE_MOD3_SEQ_FAULT_INJ_EN enables forcing of the accumulator bits and of the
//   comparator output from fault_en_bus[GID_BASE+0..2].
// Ports:
//   clk, rst_n          clock (rising edge) and async active-low reset
//   start, A, r_exp     request, operand and expected residue (captured on the accepted start)
//   fault_en_bus        per-gate fault enables
//   fault_val           value forced onto enabled gates
//   busy, done          busy while digits are consumed; done is a one-cycle result strobe
//   R, err, code_err    residue, mismatch against r_exp, illegal code 2'b11
module residue_mod3_seq #(
  parameter int W        = 32,
  parameter int NG       = 128,
  parameter int GID_BASE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [W-1:0]  A,
  input  logic [1:0]    r_exp,
  input  logic [NG-1:0] fault_en_bus,
  input  logic          fault_val,
  output logic          busy,
  output logic          done,
  output logic [1:0]    R,
  output logic          err,
  output logic          code_err
);

  localparam int N  = (W + 1) / 2;   // digit count
  localparam int SW = 2 * N;         // shift register width (odd W padded at MSB)
  localparam int CW = $clog2(N + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   sh_q, sh_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      acc_q, acc_d;
  logic [1:0]      rexp_q, rexp_d;
  logic [1:0]      r_q, r_d;
  logic            err_q, err_d;
  logic            cerr_q, cerr_d;
  logic            done_q, done_d;

  logic [1:0]      acc_base, digit, acc_raw, acc_next;
  logic [2:0]      sum;
  logic            cmp;

  // Only a few bits of the shared bus belong to this block, and none of them do when injection is compiled out.
  logic            unused_fault;
  assign unused_fault = ^{fault_en_bus, fault_val};

  // Datapath: mod-3 digit accumulate, then optional fault forcing ahead of the register.
  always_comb begin
    // A corrupted accumulator value of 3 behaves as 0. A digit of 3 is 0 mod 3.
    acc_base = (acc_q == 2'b11) ? 2'b00 : acc_q;
    digit    = (sh_q[1:0] == 2'b11) ? 2'b00 : sh_q[1:0];
    sum      = {1'b0, acc_base} + {1'b0, digit};
    acc_raw  = (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    acc_next = acc_raw;
`ifdef RESIDUE_MOD3_SEQ_FAULT_INJ_EN
    if (fault_en_bus[GID_BASE+0]) acc_next[0] = fault_val;
    if (fault_en_bus[GID_BASE+1]) acc_next[1] = fault_val;
`endif
    cmp = (acc_next != rexp_q);
`ifdef RESIDUE_MOD3_SEQ_FAULT_INJ_EN
    if (fault_en_bus[GID_BASE+2]) cmp = fault_val;
`endif
  end

  // Control: next state and register loads.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    rexp_d  = rexp_q;
    r_d     = r_q;
    err_d   = err_q;
    cerr_d  = cerr_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sh_d        = '0;
          sh_d[W-1:0] = A;
          rexp_d      = r_exp;
          acc_d       = 2'b00;
          cnt_d       = CW'(N);
          state_d     = S_RUN;
        end
      end
      S_RUN: begin
        acc_d = acc_next;
        sh_d  = sh_q >> 2;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) begin
          r_d     = acc_next;
          err_d   = cmp;
          cerr_d  = (acc_next == 2'b11);
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      acc_q   <= 2'b00;
      rexp_q  <= 2'b00;
      r_q     <= 2'b00;
      err_q   <= 1'b0;
      cerr_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rexp_q  <= rexp_d;
      r_q     <= r_d;
      err_q   <= err_d;
      cerr_q  <= cerr_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q == S_RUN);
  assign done     = done_q;
  assign R        = r_q;
  assign err      = err_q;
  assign code_err = cerr_q;

endmodule

// File: tb/tb_residue_mod3_seq.sv
// Directed bench for residue_mod3_seq across widths 8, 32, 5, 16, 1 and 2 sharing one stimulus bus.
// Instance index: 0:W8 1:W32 2:W5 3:W16 4:W1 5:W2.
module tb_residue_mod3_seq;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [31:0]  a_in;
  logic [1:0]   rexp;
  logic [127:0] fen;
  logic         fval;
  logic [5:0]   dn, bz, er, ce;
  logic [1:0]   rv [6];

  int nchk  = 0;
  int nfail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  residue_mod3_seq #(.W(8), .NG(128), .GID_BASE(0)) u8 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in[7:0]), .r_exp(rexp), .fault_en_bus(fen),
    .fault_val(fval), .busy(bz[0]), .done(dn[0]), .R(rv[0]), .err(er[0]), .code_err(ce[0]));
  residue_mod3_seq #(.W(32), .NG(128), .GID_BASE(0)) u32 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in), .r_exp(rexp), .fault_en_bus(fen),
    .fault_val(fval), .busy(bz[1]), .done(dn[1]), .R(rv[1]), .err(er[1]), .code_err(ce[1]));
  residue_mod3_seq #(.W(5), .NG(128), .GID_BASE(0)) u5 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in[4:0]), .r_exp(rexp), .fault_en_bus(fen),
    .fault_val(fval), .busy(bz[2]), .done(dn[2]), .R(rv[2]), .err(er[2]), .code_err(ce[2]));
  residue_mod3_seq #(.W(16), .NG(128), .GID_BASE(0)) u16 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in[15:0]), .r_exp(rexp), .fault_en_bus(fen),
    .fault_val(fval), .busy(bz[3]), .done(dn[3]), .R(rv[3]), .err(er[3]), .code_err(ce[3]));
  residue_mod3_seq #(.W(1), .NG(128), .GID_BASE(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in[0:0]), .r_exp(rexp), .fault_en_bus(fen),
    .fault_val(fval), .busy(bz[4]), .done(dn[4]), .R(rv[4]), .err(er[4]), .code_err(ce[4]));
  residue_mod3_seq #(.W(2), .NG(128), .GID_BASE(0)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .A(a_in[1:0]), .r_exp(rexp), .fault_en_bus(fen),
    .fault_val(fval), .busy(bz[5]), .done(dn[5]), .R(rv[5]), .err(er[5]), .code_err(ce[5]));

  // Drive one operation and wait (bounded) for done on instance sel.
  // lat = clock edges from the start edge to the done cycle (-1 on timeout), bcnt = cycles busy was seen high.
  // Unless b2b, first let every instance drain to idle. With b2b, the call is made from a done cycle.
  task automatic run(input int sel, input logic [31:0] a, input logic [1:0] re, input bit b2b,
                     output int lat, output int bcnt);
    if (!b2b) repeat (20) @(negedge clk);
    a_in  = a;
    rexp  = re;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat  = -1;
    bcnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (dn[sel]) begin
        lat = k;
        break;
      end
      if (bz[sel]) bcnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a_in = '0; rexp = '0; fen = '0; fval = 1'b0;
    #12;
    for (int i = 0; i < 6; i++) begin
      nchk++;
      if ({bz[i], dn[i], rv[i], er[i], ce[i]} !== 6'b0) begin
        nfail++;
        $display("FAIL reset_state inst=%0d got=%b exp=000000", i, {bz[i], dn[i], rv[i], er[i], ce[i]});
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic_w8();
    int lat, bc;
    run(0, 32'h7F, 2'b01, 1'b0, lat, bc);
    nchk++; if (lat !== 4) begin nfail++; $display("FAIL w8_latency got=%0d exp=4", lat); end
    nchk++; if (rv[0] !== 2'b01) begin nfail++; $display("FAIL w8_7f_R got=%b exp=01", rv[0]); end
    nchk++; if (er[0] !== 1'b0) begin nfail++; $display("FAIL w8_7f_err got=%b exp=0", er[0]); end
    nchk++; if (ce[0] !== 1'b0) begin nfail++; $display("FAIL w8_7f_code_err got=%b exp=0", ce[0]); end
    @(negedge clk);
    nchk++; if (dn[0] !== 1'b0) begin nfail++; $display("FAIL w8_done_pulse got=%b exp=0", dn[0]); end
    nchk++; if (rv[0] !== 2'b01) begin nfail++; $display("FAIL w8_R_hold got=%b exp=01", rv[0]); end
    run(0, 32'h05, 2'b00, 1'b0, lat, bc);
    nchk++; if (rv[0] !== 2'b10) begin nfail++; $display("FAIL w8_05_R got=%b exp=10", rv[0]); end
    nchk++; if (er[0] !== 1'b1) begin nfail++; $display("FAIL w8_05_err got=%b exp=1", er[0]); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    run(1, 32'hFFFF_FFFF, 2'b00, 1'b0, lat, bc);
    nchk++; if (lat !== 16) begin nfail++; $display("FAIL w32_latency got=%0d exp=16", lat); end
    nchk++; if (bc !== 16) begin nfail++; $display("FAIL w32_busy_cycles got=%0d exp=16", bc); end
    nchk++; if (rv[1] !== 2'b00) begin nfail++; $display("FAIL w32_ff_R got=%b exp=00", rv[1]); end
    nchk++; if (er[1] !== 1'b0) begin nfail++; $display("FAIL w32_ff_err got=%b exp=0", er[1]); end
    run(1, 32'h0000_0001, 2'b01, 1'b1, lat, bc);
    nchk++; if (lat !== 16) begin nfail++; $display("FAIL w32_b2b_latency got=%0d exp=16", lat); end
    nchk++; if (rv[1] !== 2'b01) begin nfail++; $display("FAIL w32_b2b_R got=%b exp=01", rv[1]); end
    nchk++; if (er[1] !== 1'b0) begin nfail++; $display("FAIL w32_b2b_err got=%b exp=0", er[1]); end
  endtask

  task automatic test_odd_and_narrow();
    int lat, bc;
    run(2, 32'd31, 2'b01, 1'b0, lat, bc);
    nchk++; if (lat !== 3) begin nfail++; $display("FAIL w5_latency got=%0d exp=3", lat); end
    nchk++; if (rv[2] !== 2'b01) begin nfail++; $display("FAIL w5_31_R got=%b exp=01", rv[2]); end
    run(2, 32'd0, 2'b00, 1'b0, lat, bc);
    nchk++; if (rv[2] !== 2'b00) begin nfail++; $display("FAIL w5_0_R got=%b exp=00", rv[2]); end
    run(4, 32'd1, 2'b01, 1'b0, lat, bc);
    nchk++; if (lat !== 1) begin nfail++; $display("FAIL w1_latency got=%0d exp=1", lat); end
    nchk++; if (rv[4] !== 2'b01) begin nfail++; $display("FAIL w1_R got=%b exp=01", rv[4]); end
    run(5, 32'd2, 2'b10, 1'b0, lat, bc);
    nchk++; if (lat !== 1) begin nfail++; $display("FAIL w2_latency got=%0d exp=1", lat); end
    nchk++; if (rv[5] !== 2'b10) begin nfail++; $display("FAIL w2_R got=%b exp=10", rv[5]); end
    nchk++; if (er[5] !== 1'b0) begin nfail++; $display("FAIL w2_err got=%b exp=0", er[5]); end
  endtask

  task automatic test_start_ignored();
    int ndone;
    logic [1:0] rsave;
    repeat (20) @(negedge clk);
    a_in = 32'h01; rexp = 2'b01; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 begin a_in = 32'h02; start = 1'b1; end
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    rsave = 2'b00;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (dn[0]) begin ndone++; rsave = rv[0]; end
    end
    nchk++; if (ndone !== 1) begin nfail++; $display("FAIL ignore_done_count got=%0d exp=1", ndone); end
    nchk++; if (rsave !== 2'b01) begin nfail++; $display("FAIL ignore_R got=%b exp=01", rsave); end
    nchk++; if (bz[0] !== 1'b0) begin nfail++; $display("FAIL ignore_busy_after got=%b exp=0", bz[0]); end
  endtask

  task automatic test_fault();
    int lat, bc;
    logic [1:0] exp_r1, exp_r2;
    logic       exp_e1, exp_c2;
`ifdef RESIDUE_MOD3_SEQ_FAULT_INJ_EN
    exp_r1 = 2'b01; exp_e1 = 1'b1; exp_r2 = 2'b11; exp_c2 = 1'b1;
`else
    exp_r1 = 2'b00; exp_e1 = 1'b0; exp_r2 = 2'b00; exp_c2 = 1'b0;
`endif
    fen = '0; fen[0] = 1'b1; fval = 1'b1;
    run(0, 32'h00, 2'b00, 1'b0, lat, bc);
    nchk++; if (rv[0] !== exp_r1) begin nfail++; $display("FAIL fault_bit0_R got=%b exp=%b", rv[0], exp_r1); end
    nchk++; if (er[0] !== exp_e1) begin nfail++; $display("FAIL fault_bit0_err got=%b exp=%b", er[0], exp_e1); end
    fen[1] = 1'b1;
    run(0, 32'h00, 2'b00, 1'b0, lat, bc);
    nchk++; if (rv[0] !== exp_r2) begin nfail++; $display("FAIL fault_both_R got=%b exp=%b", rv[0], exp_r2); end
    nchk++; if (ce[0] !== exp_c2) begin nfail++; $display("FAIL fault_both_code_err got=%b exp=%b", ce[0], exp_c2); end
    fen = '0; fval = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int lat, bc, ndone;
    run(3, 32'h0001, 2'b00, 1'b0, lat, bc);
    nchk++; if ({rv[3], er[3]} !== 3'b011) begin nfail++; $display("FAIL pre_reset_result got=%b exp=011", {rv[3], er[3]}); end
    repeat (20) @(negedge clk);
    a_in = 32'hFFFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    nchk++;
    if ({bz[3], dn[3], rv[3], er[3], ce[3]} !== 6'b0) begin
      nfail++;
      $display("FAIL midrun_reset_outputs got=%b exp=000000", {bz[3], dn[3], rv[3], er[3], ce[3]});
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (dn[3]) ndone++;
    end
    nchk++; if (ndone !== 0) begin nfail++; $display("FAIL midrun_no_done got=%0d exp=0", ndone); end
    run(3, 32'h0003, 2'b00, 1'b0, lat, bc);
    nchk++; if (lat !== 8) begin nfail++; $display("FAIL w16_latency got=%0d exp=8", lat); end
    nchk++; if (rv[3] !== 2'b00) begin nfail++; $display("FAIL w16_fresh_R got=%b exp=00", rv[3]); end
    nchk++; if (er[3] !== 1'b0) begin nfail++; $display("FAIL w16_fresh_err got=%b exp=0", er[3]); end
  endtask

  initial begin
    test_reset();
    test_basic_w8();
    test_back_to_back();
    test_odd_and_narrow();
    test_start_ignored();
    test_fault();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end

endmodule
